// File: rtl/tx_serializer_10b.sv
// tx_serializer_10b: shifts 10-bit 8b10b symbols out LSB-first, one bit per clock,
// filling empty slots with K28.5 so the line never stalls.
module tx_serializer_10b #(
   parameter int                  SYMBOL_W    = 10,
   parameter logic [SYMBOL_W-1:0] IDLE_SYMBOL = 10'h17C
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [SYMBOL_W-1:0] symbol_i,
   input  logic                symbol_valid_i,
   output logic                symbol_ready_o,
   output logic                serial_o,
   output logic                symbol_start_o,
   output logic                idle_o,
   output logic                underrun_o
);
   logic [SYMBOL_W-1:0] r_shreg;
   logic [SYMBOL_W-1:0] r_hold;
   logic [3:0]          r_bit_cnt;
   logic                r_hold_full;
   logic                r_cur_idle;
   logic                r_prev_data;
   logic                r_underrun;
   logic                w_accept;
   logic                w_boundary;

   assign w_accept       = symbol_valid_i && !r_hold_full;
   assign w_boundary     = r_bit_cnt == 4'd9;
   assign serial_o       = r_shreg[0];
   assign symbol_start_o = r_bit_cnt == 4'd0;
   assign idle_o         = r_cur_idle;
   assign symbol_ready_o = !r_hold_full;
   assign underrun_o     = r_underrun;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_shreg     <= IDLE_SYMBOL;
         r_bit_cnt   <= 4'd0;
         r_hold_full <= 1'b0;
         r_cur_idle  <= 1'b1;
         r_prev_data <= 1'b0;
         r_underrun  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_hold      <= symbol_i;
            r_hold_full <= 1'b1;
         end
         r_underrun <= 1'b0;
         // Accept needs an empty hold, so it never collides with draining it here
         if (w_boundary) begin
            r_bit_cnt   <= 4'd0;
            r_shreg     <= r_hold_full ? r_hold : IDLE_SYMBOL;
            r_cur_idle  <= !r_hold_full;
            r_prev_data <= r_hold_full;
            r_underrun  <= !r_hold_full && r_prev_data;
            if (r_hold_full) r_hold_full <= 1'b0;
         end else begin
            r_shreg   <= r_shreg >> 1;
            r_bit_cnt <= r_bit_cnt + 4'd1;
         end
      end
   end
endmodule

// File: tb/tb_tx_serializer_10b.sv
// tb_tx_serializer_10b: directed and random traffic checked every cycle against a
// slot-level model (time since reset, current slot symbol, pending queue).
module tb_tx_serializer_10b;
   localparam logic [9:0] IDLE = 10'h17C;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic [9:0] symbol_i = '0;
   logic       symbol_valid_i = 1'b0;
   logic       symbol_ready_o;
   logic       serial_o;
   logic       symbol_start_o;
   logic       idle_o;
   logic       underrun_o;

   int         n_vec = 0;
   int         n_err = 0;
   int         m_t;
   logic [9:0] m_cur;
   logic       m_idle;
   logic       m_und;
   logic [9:0] m_q[$];
   logic       last_acc;
   logic [9:0] cnt;

   tx_serializer_10b dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .symbol_i       (symbol_i),
      .symbol_valid_i (symbol_valid_i),
      .symbol_ready_o (symbol_ready_o),
      .serial_o       (serial_o),
      .symbol_start_o (symbol_start_o),
      .idle_o         (idle_o),
      .underrun_o     (underrun_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         if (n_err <= 30) $display("FAIL %s t=%0d got=%h exp=%h", tag, m_t, got, exp);
      end
   endtask

   task automatic model_reset();
      m_t    = 0;
      m_cur  = IDLE;
      m_idle = 1'b1;
      m_und  = 1'b0;
      m_q.delete();
   endtask

   // check the current cycle, then drive inputs for the next edge and advance the model
   task automatic step(input logic rst_n, input logic v, input logic [9:0] d);
      @(negedge clk_i);
      chk("serial", {9'b0, serial_o}, {9'b0, m_cur[m_t % 10]});
      chk("start", {9'b0, symbol_start_o}, {9'b0, (m_t % 10) == 0});
      chk("idle", {9'b0, idle_o}, {9'b0, m_idle});
      chk("ready", {9'b0, symbol_ready_o}, {9'b0, m_q.size() == 0});
      chk("underrun", {9'b0, underrun_o}, {9'b0, m_und});
      rst_ni         = rst_n;
      symbol_valid_i = v;
      symbol_i       = d;
      last_acc       = 1'b0;
      if (!rst_n) model_reset();
      else begin
         last_acc = v && m_q.size() == 0;
         if (m_t % 10 == 9) begin
            if (m_q.size() != 0) begin
               m_cur  = m_q.pop_front();
               m_idle = 1'b0;
               m_und  = 1'b0;
            end else begin
               m_und  = !m_idle;
               m_cur  = IDLE;
               m_idle = 1'b1;
            end
         end else m_und = 1'b0;
         if (last_acc) m_q.push_back(d);
         m_t++;
      end
   endtask

   task automatic idle_until(input int pos);
      for (int i = 0; i < 10 && (m_t % 10) != pos; i++) step(1'b1, 1'b0, 10'($urandom));
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk_i);
      step(1'b0, 1'b1, 10'h3FF);
      for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 10'($urandom));
      idle_until(8);
      step(1'b1, 1'b1, 10'h2A5);
      for (int i = 0; i < 25; i++) step(1'b1, 1'b0, 10'($urandom));
      cnt = 10'h000;
      for (int i = 0; i < 80; i++) begin
         step(1'b1, 1'b1, cnt);
         if (last_acc) cnt++;
      end
      for (int i = 0; i < 22; i++) step(1'b1, 1'b0, 10'($urandom));
      idle_until(9);
      step(1'b1, 1'b1, 10'h155);
      for (int i = 0; i < 25; i++) step(1'b1, 1'b0, 10'($urandom));
      idle_until(8);
      step(1'b1, 1'b1, 10'h0F0);
      idle_until(1);
      step(1'b1, 1'b1, 10'h3C3);
      idle_until(4);
      step(1'b0, 1'b1, 10'h2AA);
      for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 10'($urandom));
      for (int i = 0; i < 800; i++)
         step($urandom_range(0, 99) != 0, $urandom_range(0, 2) != 0, 10'($urandom));
      step(1'b1, 1'b0, 10'h000);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
